// File: rtl/fetch.sv
// Instruction fetch unit: reads 16-bit words over a req/ack port, pairs each instruction with its optional extension word and issues it to decode.
// Optional feature: define FETCH_ISSUE_COUNT_EN to add the issue_count output (accepted-transfer counter).
module fetch #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] EXT_MASK  = 16'hF000,
    parameter logic [15:0] EXT_MATCH = 16'hF000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] ins,
    output logic [15:0] ext,
    output logic        ins_en,
    input  logic        dec_ready,
    output logic [15:0] ins_pc,
    input  logic        redirect_en,
    input  logic [15:0] redirect_pc
`ifdef FETCH_ISSUE_COUNT_EN
    ,
    output logic [15:0] issue_count
`endif
);

    localparam logic [1:0] FETCH_INS = 2'd0;
    localparam logic [1:0] FETCH_EXT = 2'd1;
    localparam logic [1:0] ISSUE     = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ins_q, ins_d;
    logic [15:0] ext_q, ext_d;
    logic [15:0] ins_pc_q, ins_pc_d;
    logic        live_s;
    logic        xfer_s;

    function automatic logic has_ext(input logic [15:0] word);
        return (word & EXT_MASK) == EXT_MATCH;
    endfunction

    // Reset and redirect both silence the handshakes in the cycle they are seen.
    assign live_s   = ~cpu_rst & ~redirect_en;
    assign mem_req  = live_s & ((state_q == FETCH_INS) | (state_q == FETCH_EXT));
    assign mem_addr = pc_q;
    assign ins_en   = live_s & (state_q == ISSUE);
    assign xfer_s   = ins_en & dec_ready;
    assign ins      = ins_q;
    assign ext      = ext_q;
    assign ins_pc   = ins_pc_q;

    // Next-state logic; redirect wins over any memory ack or decode handshake.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ins_d    = ins_q;
        ext_d    = ext_q;
        ins_pc_d = ins_pc_q;
        if (redirect_en) begin
            pc_d    = redirect_pc;
            state_d = FETCH_INS;
        end else begin
            case (state_q)
                FETCH_INS: begin
                    if (mem_ack) begin
                        ins_d    = mem_rdata;
                        ins_pc_d = pc_q;
                        pc_d     = pc_q + 16'd1;
                        if (has_ext(mem_rdata)) begin
                            state_d = FETCH_EXT;
                        end else begin
                            ext_d   = 16'h0000;
                            state_d = ISSUE;
                        end
                    end else begin
                        state_d = FETCH_INS;
                    end
                end
                FETCH_EXT: begin
                    if (mem_ack) begin
                        ext_d   = mem_rdata;
                        pc_d    = pc_q + 16'd1;
                        state_d = ISSUE;
                    end else begin
                        state_d = FETCH_EXT;
                    end
                end
                ISSUE: begin
                    if (xfer_s) begin
                        state_d = FETCH_INS;
                    end else begin
                        state_d = ISSUE;
                    end
                end
                default: begin
                    state_d = FETCH_INS;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q  <= FETCH_INS;
            pc_q     <= RESET_PC;
            ins_q    <= 16'h0000;
            ext_q    <= 16'h0000;
            ins_pc_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ins_q    <= ins_d;
            ext_q    <= ext_d;
            ins_pc_q <= ins_pc_d;
        end
    end

`ifdef FETCH_ISSUE_COUNT_EN
    logic [15:0] count_q;

    // Counts accepted transfers only; wraps naturally at 16 bits.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            count_q <= 16'h0000;
        end else if (xfer_s) begin
            count_q <= count_q + 16'd1;
        end else begin
            count_q <= count_q;
        end
    end

    assign issue_count = count_q;
`endif

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: a program-order model predicts each issued instruction; directed phases cover reset, waits, backpressure, redirect and wrap.
module tb_fetch;

    localparam logic [15:0] RPC = 16'h0010;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] ins, ext, ins_pc;
    logic        ins_en;
    logic        dec_ready;
    logic        redirect_en;
    logic [15:0] redirect_pc;
    logic        ack_en;
`ifdef FETCH_ISSUE_COUNT_EN
    logic [15:0] issue_count;
`endif

    logic [15:0] mem [0:65535];

    typedef struct {
        logic [15:0] ins;
        logic [15:0] ext;
        logic [15:0] pc;
        logic [15:0] nxt;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   xfer_cnt = 0;

    always #5 cpu_clk = ~cpu_clk;

    assign mem_ack   = mem_req & ack_en;
    assign mem_rdata = mem_ack ? mem[mem_addr] : 16'hDEAD;

    fetch #(.RESET_PC(RPC), .EXT_MASK(16'hF000), .EXT_MATCH(16'hF000)) dut (
        .cpu_clk     (cpu_clk),
        .cpu_rst     (cpu_rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .ins         (ins),
        .ext         (ext),
        .ins_en      (ins_en),
        .dec_ready   (dec_ready),
        .ins_pc      (ins_pc),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc)
`ifdef FETCH_ISSUE_COUNT_EN
        ,
        .issue_count (issue_count)
`endif
    );

    task automatic chk(input bit ok, input string nm, input logic [15:0] act, input logic [15:0] req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    // The instruction found at address a, as decode should see it.
    function automatic exp_t exp_of(input logic [15:0] a);
        exp_t e;
        logic [15:0] a1;
        a1    = a + 16'd1;
        e.pc  = a;
        e.ins = mem[a];
        if ((e.ins & 16'hF000) == 16'hF000) begin
            e.ext = mem[a1];
            e.nxt = a + 16'd2;
        end else begin
            e.ext = 16'h0000;
            e.nxt = a1;
        end
        return e;
    endfunction

    logic        p_rst = 1'b0, p_req = 1'b0, p_ack = 1'b0, p_insen = 1'b0, p_rdy = 1'b0, p_redir = 1'b0;
    logic [15:0] p_addr, p_ins, p_ext, p_ipc, p_rpc;

    // Monitor: scoreboard pops on every accepted transfer plus hold/redirect timing checks.
    always @(negedge cpu_clk) begin
        exp_t e;
        if (cpu_rst) begin
            chk(!mem_req && !ins_en, "rst_gate", {14'd0, mem_req, ins_en}, 16'h0000);
            if (p_rst) begin
                chk(ins == 16'h0 && ext == 16'h0 && ins_pc == 16'h0, "rst_vals", ins | ext | ins_pc, 16'h0000);
            end
            exp_q.delete();
            exp_q.push_back(exp_of(RPC));
        end else begin
            if (p_req && !p_ack && !redirect_en) begin
                chk(mem_req && mem_addr == p_addr, "req_hold", mem_addr, p_addr);
            end
            if (p_insen && !p_rdy && !redirect_en) begin
                chk(ins_en && ins == p_ins && ext == p_ext && ins_pc == p_ipc, "issue_hold", ins, p_ins);
            end
            if (p_redir && !p_rst && !redirect_en) begin
                chk(mem_req && mem_addr == p_rpc, "redir_next", mem_addr, p_rpc);
            end
            if (redirect_en) begin
                chk(!mem_req && !ins_en, "redir_gate", {14'd0, mem_req, ins_en}, 16'h0000);
                exp_q.delete();
                exp_q.push_back(exp_of(redirect_pc));
            end else if (ins_en && dec_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "sb_empty", ins, 16'h0000);
                end else begin
                    e = exp_q.pop_front();
                    chk(ins == e.ins, "sb_ins", ins, e.ins);
                    chk(ext == e.ext, "sb_ext", ext, e.ext);
                    chk(ins_pc == e.pc, "sb_pc", ins_pc, e.pc);
                    exp_q.push_back(exp_of(e.nxt));
                end
            end
        end
        p_rst   = cpu_rst;
        p_req   = mem_req;
        p_ack   = mem_ack;
        p_addr  = mem_addr;
        p_insen = ins_en;
        p_rdy   = dec_ready;
        p_ins   = ins;
        p_ext   = ext;
        p_ipc   = ins_pc;
        p_redir = redirect_en;
        p_rpc   = redirect_pc;
    end

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge cpu_clk);
    endtask

    task automatic chk_fetch(input string nm, input logic [15:0] a);
        chk(mem_req && mem_addr == a, nm, mem_addr, a);
    endtask

    task automatic chk_issue(input string nm, input logic [15:0] i, input logic [15:0] x, input logic [15:0] p);
        chk(ins_en && !mem_req && ins == i && ext == x && ins_pc == p, nm, ins, i);
    endtask

    int          cnt_before;
`ifdef FETCH_ISSUE_COUNT_EN
    logic [15:0] hw_before;
`endif

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 16'($urandom);
            if ($urandom_range(9, 0) < 3) mem[i][15:12] = 4'hF;
        end
        mem[RPC]    = 16'h1234;
        cpu_rst     = 1'b1;
        redirect_en = 1'b0;
        redirect_pc = 16'h0000;
        dec_ready   = 1'b1;
        ack_en      = 1'b1;

        // Reset, with a redirect that reset must override.
        step();
        step();
        redirect_en = 1'b1;
        redirect_pc = 16'h0777;
        step();
        redirect_en = 1'b0;
        cpu_rst     = 1'b0;
        at_neg();
        chk_fetch("first_fetch", RPC);
        step();
        at_neg();
        chk_issue("first_issue", 16'h1234, 16'h0000, RPC);

        // Two-word instruction at address 0.
        step();
        redirect_en = 1'b1;
        redirect_pc = 16'h0000;
        mem[0] = 16'hF001;
        mem[1] = 16'hBEEF;
        mem[2] = 16'h1111;
        mem[3] = 16'h2222;
        step();
        redirect_en = 1'b0;
        at_neg();
        chk_fetch("w2_ins", 16'h0000);
        step();
        at_neg();
        chk_fetch("w2_ext", 16'h0001);
        step();
        at_neg();
        chk_issue("w2_issue", 16'hF001, 16'hBEEF, 16'h0000);
        step();
        at_neg();
        chk_fetch("w2_next", 16'h0002);

        // Backpressure for five cycles in ISSUE.
        step();
        dec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            at_neg();
            chk_issue("bp_hold", 16'h1111, 16'h0000, 16'h0002);
            step();
        end
        cnt_before = xfer_cnt;
        dec_ready  = 1'b1;
        ack_en     = 1'b0;
        at_neg();
        chk_issue("bp_release", 16'h1111, 16'h0000, 16'h0002);

        // Memory wait of three cycles on the next fetch.
        for (int i = 0; i < 3; i++) begin
            step();
            at_neg();
            chk_fetch("wait_hold", 16'h0003);
        end
        chk(xfer_cnt == cnt_before + 1, "bp_one_xfer", 16'(xfer_cnt - cnt_before), 16'h0001);
        step();
        ack_en = 1'b1;
        at_neg();
        chk_fetch("wait_ack", 16'h0003);
        step();
        at_neg();
        chk_issue("wait_issue", 16'h2222, 16'h0000, 16'h0003);

        // Redirect during FETCH_EXT, then coincident with a transfer.
        step();
        redirect_en = 1'b1;
        redirect_pc = 16'h0100;
        mem[16'h0100] = 16'hF00A;
        mem[16'h0101] = 16'h0B0B;
        mem[16'h0400] = 16'h3333;
        step();
        redirect_en = 1'b0;
        at_neg();
        chk_fetch("rd_ins", 16'h0100);
        step();
        redirect_en = 1'b1;
        redirect_pc = 16'h0400;
        at_neg();
        chk(!mem_req, "rd_ext_gate", {15'd0, mem_req}, 16'h0000);
        step();
        redirect_en = 1'b0;
        at_neg();
        chk_fetch("rd_target", 16'h0400);
        step();
        cnt_before  = xfer_cnt;
`ifdef FETCH_ISSUE_COUNT_EN
        hw_before   = issue_count;
`endif
        redirect_en = 1'b1;
        redirect_pc = 16'h0400;
        dec_ready   = 1'b1;
        at_neg();
        chk(!ins_en, "rd_issue_gate", {15'd0, ins_en}, 16'h0000);
        step();
        redirect_en = 1'b0;
        at_neg();
        chk_fetch("rd_target2", 16'h0400);
        chk(xfer_cnt == cnt_before, "rd_no_xfer", 16'(xfer_cnt - cnt_before), 16'h0000);
`ifdef FETCH_ISSUE_COUNT_EN
        chk(issue_count == hw_before, "rd_count", issue_count, hw_before);
`endif

        // Extension word wraps from 16'hFFFF to 16'h0000.
        step();
        redirect_en   = 1'b1;
        redirect_pc   = 16'hFFFF;
        mem[16'hFFFF] = 16'hF000;
        mem[16'h0000] = 16'h5555;
        mem[16'h0001] = 16'h0666;
        step();
        redirect_en = 1'b0;
        at_neg();
        chk_fetch("wrap_ins", 16'hFFFF);
        step();
        at_neg();
        chk_fetch("wrap_ext", 16'h0000);
        step();
        at_neg();
        chk_issue("wrap_issue", 16'hF000, 16'h5555, 16'hFFFF);
        step();
        at_neg();
        chk_fetch("wrap_next", 16'h0001);

        // Randomised traffic: waits, backpressure and redirects.
        cnt_before = xfer_cnt;
        for (int c = 0; c < 4000; c++) begin
            step();
            ack_en      = ($urandom_range(3, 0) != 0);
            dec_ready   = ($urandom_range(9, 0) < 7);
            redirect_en = ($urandom_range(39, 0) == 0);
            redirect_pc = 16'($urandom);
            if ($urandom_range(3, 0) == 0) redirect_pc = 16'hFFFE + 16'($urandom_range(1, 0));
        end
        step();
        redirect_en = 1'b0;
        at_neg();
        chk(xfer_cnt - cnt_before > 200, "rand_progress", 16'(xfer_cnt - cnt_before), 16'd200);
`ifdef FETCH_ISSUE_COUNT_EN
        chk(issue_count == 16'(xfer_cnt), "count_total", issue_count, 16'(xfer_cnt));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
